// File: rtl/lcell_cfg_loader_pkg.sv
// Shared definitions for the logic-cell configuration loader: FSM states,
// frame header opcode and bit positions of the per-cell static select word.
package lcell_cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } ld_state_t;

    localparam logic [3:0] HDR_OPCODE = 4'hC;

    // Bit positions inside one cell's CFG_W-wide config word
    localparam int CFG_TAS1 = 0;
    localparam int CFG_TAS2 = 1;
    localparam int CFG_TBS1 = 2;
    localparam int CFG_TBS2 = 3;
    localparam int CFG_BAS1 = 4;
    localparam int CFG_BAS2 = 5;
    localparam int CFG_BBS1 = 6;
    localparam int CFG_BBS2 = 7;
    localparam int CFG_QCKS = 8;
    localparam int CFG_QDS  = 9;

endpackage

// File: rtl/lcell_cfg_slot.sv
// One cell's config storage: a shadow register filled during a load, a mask
// bit recording that the shadow was written in this frame, and the active
// register that drives the cell. Active only changes on commit, and only if
// this slot was written by the frame being committed.
module lcell_cfg_slot #(
    parameter int               CFG_W    = 10,
    parameter logic [CFG_W-1:0] INIT_CFG = 10'h100
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             wr_en,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             clr_mask,
    input  logic             commit,
    output logic [CFG_W-1:0] active
);

    logic [CFG_W-1:0] shadow_q;
    logic             mask_q;

    // Shadow capture and frame-membership mask; clear wins over write
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            shadow_q <= '0;
            mask_q   <= 1'b0;
        end else if (clr_mask) begin
            mask_q   <= 1'b0;
        end else if (wr_en) begin
            shadow_q <= wr_data;
            mask_q   <= 1'b1;
        end
    end

    // Atomic transfer of shadow to the live cell config
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            active <= INIT_CFG;
        else if (commit && mask_q)
            active <= shadow_q;
    end

endmodule

// File: rtl/lcell_cfg_loader.sv
// Framed config loader for a logic-cell array. Accepts header, data words and
// an XOR checksum, stages data in per-cell shadow slots and commits them all
// on one edge once the checksum matches. Cells are held in reset while a
// frame is in flight.
module lcell_cfg_loader
    import lcell_cfg_loader_pkg::*;
#(
    parameter int               NUM_CELLS = 8,
    parameter int               DW        = 16,
    parameter int               CFG_W     = 10,
    parameter logic [CFG_W-1:0] INIT_CFG  = 10'h100
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic [DW-1:0]              IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       ABORT,
    input  logic                       ERR_CLR,
    output logic [NUM_CELLS*CFG_W-1:0] CFG_OUT,
    output logic                       CELL_HOLD,
    output logic                       DONE,
    output logic                       ERR,
    output logic                       ERR_STS
);

    localparam int CW = $clog2(NUM_CELLS + 1);

    ld_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sts_q, sts_d;

    logic          xfer;
    logic          wr_en;
    logic          commit;
    logic          clr_mask;
    logic [3:0]    hdr_op;
    logic [DW-5:0] hdr_cnt;
    logic          hdr_ok;

    assign IN_READY = (state_q != COMMIT);
    assign xfer     = IN_VALID & IN_READY;
    assign hdr_op   = IN_DATA[DW-1 -: 4];
    assign hdr_cnt  = IN_DATA[DW-5:0];
    assign hdr_ok   = (hdr_op == HDR_OPCODE) && (hdr_cnt != '0) &&
                      (32'(hdr_cnt) <= NUM_CELLS);

    // Control registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sts_q   <= sts_d;
        end
    end

    // Next-state, slot controls and status; ABORT overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        commit   = 1'b0;
        clr_mask = 1'b0;
        if (ABORT) begin
            state_d  = IDLE;
            clr_mask = 1'b1;
            hold_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (!hdr_ok) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d    = CW'(hdr_cnt);
                            idx_d    = '0;
                            acc_d    = '0;
                            clr_mask = 1'b1;
                            hold_d   = 1'b1;
                            state_d  = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        acc_d = acc_q ^ IN_DATA;
                        idx_d = idx_q + CW'(1);
                        if (idx_q == cnt_q - CW'(1))
                            state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (IN_DATA == acc_q) begin
                            state_d = COMMIT;
                        end else begin
                            err_d    = 1'b1;
                            clr_mask = 1'b1;
                            hold_d   = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                end
                COMMIT: begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // A new error in the same cycle as a clear leaves the flag set
        if (err_d)
            sts_d = 1'b1;
        else if (ERR_CLR)
            sts_d = 1'b0;
        else
            sts_d = sts_q;
    end

    assign CELL_HOLD = hold_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign ERR_STS   = sts_q;

    // Per-cell storage; write decode from the running word index
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_slot
        logic [CFG_W-1:0] slot_cfg;

        lcell_cfg_slot #(
            .CFG_W    (CFG_W),
            .INIT_CFG (INIT_CFG)
        ) u_slot (
            .CLK      (CLK),
            .RSTN     (RSTN),
            .wr_en    (wr_en && (idx_q == CW'(i))),
            .wr_data  (IN_DATA[CFG_W-1:0]),
            .clr_mask (clr_mask),
            .commit   (commit),
            .active   (slot_cfg)
        );

        assign CFG_OUT[i*CFG_W +: CFG_W] = slot_cfg;
    end

endmodule
